fifo_rd_arbiter: RTL and testbench

FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/fifo_rd_arbiter_rr_arbiter.sv | 40 ++++
 rtl/fifo_rd_arbiter.sv | 124 ++++++++++++
 tb/tb_fifo_rd_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO read-port burst arbiter.
package fifo_arb_pkg;

  localparam int NREQ_DEF  = 4;
  localparam int DSIZE_DEF = 8;
  localparam int LENW_DEF  = 4;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  // Increment with wrap at n; used for the round-robin pointer.
  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/fifo_rd_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester at or after rr_ptr.
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic [NREQ-1:0]         eligible,
  input  logic [$clog2(NREQ)-1:0] rr_ptr,
  output logic [NREQ-1:0]         pick,
  output logic [$clog2(NREQ)-1:0] pick_idx,
  output logic                    pick_valid
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW:0]   slot;
  logic [IDW-1:0] cand;

  always_comb begin
    pick       = '0;
    pick_idx   = '0;
    pick_valid = 1'b0;
    slot       = '0;
    cand       = '0;
    for (int k = 0; k < NREQ; k++) begin
      // One extra bit so rr_ptr + k can be folded back for non-power-of-two NREQ.
      slot = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (slot >= (IDW+1)'(NREQ)) begin
        slot = slot - (IDW+1)'(NREQ);
      end
      cand = slot[IDW-1:0];
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
        pick[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Grants the FIFO read port to one requester at a time for a fixed-length burst,
// popping one word per non-empty cycle and delivering it tagged with the requester id.
//
// state | meaning
// IDLE  | no burst; arbitrate among eligible requesters each cycle
// XFER  | burst in progress; pop while FIFO non-empty and winner still requesting
module fifo_rd_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int DSIZE = DSIZE_DEF,
  parameter int LENW  = LENW_DEF
) (
  input  logic                       rclk,
  input  logic                       rrst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0][LENW-1:0]  req_len,
  input  logic                       rempty,
  input  logic [DSIZE-1:0]           rdata,
  output logic                       rinc,
  output logic [NREQ-1:0]            gnt,
  output logic                       out_valid,
  output logic [DSIZE-1:0]           out_data,
  output logic [$clog2(NREQ)-1:0]    out_id,
  output logic                       burst_done,
  output logic                       busy
);

  localparam int IDW = $clog2(NREQ);

  state_t          state;
  logic [IDW-1:0]  winner;
  logic [IDW-1:0]  rr_ptr;
  logic [LENW-1:0] count;

  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] pick;
  logic [IDW-1:0]  pick_idx;
  logic            pick_valid;

  logic            xfer;
  logic            win_req;
  logic            last_pop;
  logic            burst_end;
  logic [IDW-1:0]  next_ptr;

  // A zero-length request would never complete a pop, so it is never eligible.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req[i] && (req_len[i] != '0);
    end
  end

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_rr_arbiter (
    .eligible  (eligible),
    .rr_ptr    (rr_ptr),
    .pick      (pick),
    .pick_idx  (pick_idx),
    .pick_valid(pick_valid)
  );

  assign xfer      = (state == XFER);
  assign win_req   = req[winner];
  assign rinc      = xfer && !rempty && win_req;
  assign last_pop  = rinc && (count == LENW'(1));
  assign burst_end = xfer && (!win_req || last_pop);
  assign next_ptr  = IDW'(wrap_inc(int'(winner), NREQ));
  assign busy      = xfer;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state      <= IDLE;
      gnt        <= '0;
      winner     <= '0;
      rr_ptr     <= '0;
      count      <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= burst_end;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state  <= XFER;
            winner <= pick_idx;
            count  <= req_len[pick_idx];
            gnt    <= pick;
          end
        end
        XFER: begin
          // Normal completion and requester abort share the same exit path.
          if (burst_end) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= next_ptr;
          end else if (rinc) begin
            count <= count - LENW'(1);
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
    end else begin
      out_valid <= rinc;
      if (rinc) begin
        out_data <= rdata;
        out_id   <= winner;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Self-checking bench for fifo_rd_arbiter: vector table, directed corner sequences, random run.
module tb_fifo_rd_arbiter;

  logic            rclk;
  logic            rrst;
  logic [3:0]      req;
  logic [3:0][3:0] req_len;
  logic            rempty;
  logic [7:0]      rdata;
  logic            rinc;
  logic [3:0]      gnt;
  logic            out_valid;
  logic [7:0]      out_data;
  logic [1:0]      out_id;
  logic            burst_done;
  logic            busy;

  fifo_rd_arbiter #(
    .NREQ (4),
    .DSIZE(8),
    .LENW (4)
  ) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .req       (req),
    .req_len   (req_len),
    .rempty    (rempty),
    .rdata     (rdata),
    .rinc      (rinc),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .burst_done(burst_done),
    .busy      (busy)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: one burst at a time, round-robin after the last winner.
  bit         m_xfer;
  int         m_who;
  int         m_left;
  int         m_ptr;
  bit         m_ov;
  bit         m_done;
  logic [7:0] m_od;
  int         m_oid;

  int         pops;
  int         dones;
  int         grant_log[$];
  logic [3:0] prev_gnt;

  task automatic model_reset();
    m_xfer = 0; m_who = 0; m_left = 0; m_ptr = 0;
    m_ov = 0; m_done = 0; m_od = 8'h00; m_oid = 0;
  endtask

  task automatic model_edge();
    bit fire;
    bit found;
    int i;
    if (rrst) begin
      model_reset();
      return;
    end
    fire   = m_xfer && !rempty && req[m_who];
    m_done = 0;
    if (fire) begin
      m_od  = rdata;
      m_oid = m_who;
    end
    if (m_xfer) begin
      if (!req[m_who] || (fire && m_left == 1)) begin
        m_xfer = 0;
        m_done = 1;
        m_ptr  = (m_who + 1) % 4;
      end else if (fire) begin
        m_left = m_left - 1;
      end
    end else begin
      found = 0;
      for (int k = 0; k < 4; k++) begin
        i = (m_ptr + k) % 4;
        if (!found && req[i] && req_len[i] != 0) begin
          found  = 1;
          m_xfer = 1;
          m_who  = i;
          m_left = int'(req_len[i]);
        end
      end
    end
    m_ov = fire;
  endtask

  task automatic check_outputs();
    logic [3:0] eg;
    logic       er;
    eg = m_xfer ? (4'b0001 << m_who) : 4'b0000;
    er = m_xfer && !rempty && req[m_who];
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
    chk("busy", 32'(busy), 32'(m_xfer));
    chk("rinc", 32'(rinc), 32'(er));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("burst_done", 32'(burst_done), 32'(m_done));
    if (m_ov) begin
      chk("out_data", 32'(out_data), 32'(m_od));
      chk("out_id", 32'(out_id), m_oid);
    end
    if (rinc) pops++;
    if (burst_done) dones++;
    if (gnt != 4'b0000 && prev_gnt == 4'b0000) begin
      for (int k = 0; k < 4; k++) if (gnt[k]) grant_log.push_back(k);
    end
    prev_gnt = gnt;
  endtask

  task automatic cycle(input logic rs, input logic [3:0] r, input logic [15:0] l,
                       input logic e, input logic [7:0] d);
    @(posedge rclk);
    model_edge();
    #2;
    rrst = rs; req = r; req_len = l; rempty = e; rdata = d;
    if (rs) model_reset();
    #2;
    check_outputs();
  endtask

  task automatic clear_obs();
    pops = 0;
    dones = 0;
    grant_log.delete();
  endtask

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [15:0] len;
    logic        rempty;
    logic [7:0]  rdata;
    logic [3:0]  gnt;
    logic        rinc;
    logic        ov;
    logic [7:0]  od;
    logic [1:0]  oid;
    logic        done;
    logic        busy;
  } vec_t;

  vec_t tbl[12];

  logic [3:0]      r_req;
  logic [3:0][3:0] r_len;

  initial begin
    rrst = 1'b1; req = '0; req_len = '0; rempty = 1'b0; rdata = '0;
    prev_gnt = 4'b0000;
    model_reset();
    clear_obs();

    //          rst  req    len       emp  rdata  | gnt   rinc ov  od     oid  done busy
    tbl[0]  = '{1'b1, 4'h0, 16'h0000, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 4'h1, 16'h0003, 1'b0, 8'h55, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 4'h1, 16'h0003, 1'b0, 8'hA0, 4'h1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[3]  = '{1'b0, 4'h1, 16'h0003, 1'b0, 8'hA1, 4'h1, 1'b1, 1'b1, 8'hA0, 2'd0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'h1, 16'h0003, 1'b0, 8'hA2, 4'h1, 1'b1, 1'b1, 8'hA1, 2'd0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 8'h77, 4'h0, 1'b0, 1'b1, 8'hA2, 2'd0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'h0, 16'h0000, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 4'hA, 16'h2000, 1'b0, 8'h66, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 4'hA, 16'h2000, 1'b0, 8'hB0, 4'h8, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, 4'hA, 16'h2000, 1'b0, 8'hB1, 4'h8, 1'b1, 1'b1, 8'hB0, 2'd3, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 4'h0, 16'h0000, 1'b0, 8'h00, 4'h0, 1'b0, 1'b1, 8'hB1, 2'd3, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'h0, 16'h0000, 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      @(posedge rclk);
      #2;
      rrst = tbl[i].rst; req = tbl[i].req; req_len = tbl[i].len;
      rempty = tbl[i].rempty; rdata = tbl[i].rdata;
      #2;
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      chk($sformatf("tbl%0d_rinc", i), 32'(rinc), 32'(tbl[i].rinc));
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
      chk($sformatf("tbl%0d_burst_done", i), 32'(burst_done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      if (tbl[i].ov || tbl[i].rst) begin
        chk($sformatf("tbl%0d_out_data", i), 32'(out_data), 32'(tbl[i].od));
        chk($sformatf("tbl%0d_out_id", i), 32'(out_id), 32'(tbl[i].oid));
      end
    end

    cycle(1'b1, 4'h0, 16'h0000, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);

    // All four requesting single-word bursts: rotation 0,1,2,3,0.
    clear_obs();
    for (int n = 0; n < 10; n++) cycle(1'b0, 4'hF, 16'h1111, 1'b0, 8'($urandom));
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);
    chk("rr_grants", grant_log.size(), 5);
    for (int k = 0; k < 5 && k < grant_log.size(); k++) chk("rr_order", grant_log[k], k % 4);
    chk("rr_pops", pops, 5);
    chk("rr_dones", dones, 5);

    // Empty FIFO stalls the burst for five cycles after the first pop.
    clear_obs();
    for (int n = 0; n < 10; n++) begin
      cycle(1'b0, 4'h1, 16'h0004, (n >= 2 && n <= 6), 8'(8'hC0 + n));
      if (n >= 2 && n <= 6) chk("stall_rinc", 32'(rinc), 32'(0));
    end
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);
    chk("stall_pops", pops, 4);
    chk("stall_dones", dones, 1);
    chk("stall_grants", grant_log.size(), 1);

    // Requester 2 drops after three pops; requester 3 must win next.
    clear_obs();
    for (int n = 0; n < 4; n++) cycle(1'b0, 4'h4, 16'h0800, 1'b0, 8'($urandom));
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h11);
    chk("abort_rinc", 32'(rinc), 32'(0));
    cycle(1'b0, 4'hF, 16'h1111, 1'b0, 8'h22);
    chk("abort_done", 32'(burst_done), 32'(1));
    cycle(1'b0, 4'hF, 16'h1111, 1'b0, 8'h33);
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);
    chk("abort_pops", pops, 4);
    chk("abort_dones", dones, 2);
    chk("abort_grants", grant_log.size(), 2);
    if (grant_log.size() >= 2) begin
      chk("abort_first", grant_log[0], 2);
      chk("abort_next", grant_log[1], 3);
    end

    // Reset two pops into a burst, with the round-robin pointer left at 3.
    clear_obs();
    cycle(1'b0, 4'h4, 16'h0100, 1'b0, 8'h40);
    cycle(1'b0, 4'h4, 16'h0100, 1'b0, 8'h41);
    cycle(1'b0, 4'h4, 16'h0500, 1'b0, 8'h42);
    cycle(1'b0, 4'h4, 16'h0500, 1'b0, 8'h43);
    cycle(1'b0, 4'h4, 16'h0500, 1'b0, 8'h44);
    cycle(1'b1, 4'h4, 16'h0500, 1'b0, 8'h45);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_out_data", 32'(out_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    cycle(1'b1, 4'h4, 16'h0500, 1'b0, 8'h46);
    cycle(1'b0, 4'hE, 16'h1110, 1'b0, 8'h47);
    cycle(1'b0, 4'hE, 16'h1110, 1'b0, 8'h48);
    cycle(1'b0, 4'h0, 16'h0000, 1'b0, 8'h00);
    chk("rst_dones", dones, 2);
    chk("rst_pops", pops, 4);
    chk("rst_grants", grant_log.size(), 3);
    if (grant_log.size() >= 3) chk("rst_rearb", grant_log[2], 1);

    // Random traffic against the reference model.
    r_req = 4'h0;
    r_len = 16'h3251;
    for (int n = 0; n < 3000; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(7) == 0) r_req[b] = ~r_req[b];
      if ($urandom_range(3) == 0) r_len[$urandom_range(3)] = 4'($urandom_range(15));
      cycle(($urandom_range(499) == 0), r_req, r_len, ($urandom_range(9) < 3), 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
